// File: rtl/kl10pv_pkg.sv
// rtl/kl10pv_pkg.sv - shared KL10 MBOX types: word width, MBUS phase, read request
package kl10pv;

  localparam int W36 = 36;

  typedef enum logic {PH_A = 1'b0, PH_B = 1'b1} mbus_phase_t;

  typedef struct packed {
    logic [14:35] adr;
    logic [0:3]   mask;
  } mbus_req_t;

  // Leftmost set bit of a [0:3] word mask; mask bit k names quadword word adr+k.
  function automatic logic [1:0] first_set(input logic [0:3] m);
    first_set = 2'd0;
    for (int k = 3; k >= 0; k--) begin
      if (m[k]) first_set = 2'(k);
    end
  endfunction

endpackage

// File: rtl/mbus_rr_arb.sv
// rtl/mbus_rr_arb.sv - round-robin arbiter over NREQ requesters
module mbus_rr_arb #(
  parameter int NREQ = 2,
  localparam int IDW = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [NREQ-1:0] req,
  input  logic            advance,
  output logic [NREQ-1:0] grant,
  output logic [IDW-1:0]  id,
  output logic            any
);

  logic [IDW-1:0] ptr;

  // Search starts at ptr and wraps, so the most recently served requester goes last.
  always_comb begin
    logic [IDW-1:0] idx;
    grant = '0;
    id    = '0;
    any   = 1'b0;
    idx   = '0;
    for (int i = 0; i < NREQ; i++) begin
      idx = IDW'((int'(ptr) + i) % NREQ);
      if (!any && req[idx]) begin
        any        = 1'b1;
        id         = idx;
        grant[idx] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ptr <= '0;
    end else if (advance) begin
      ptr <= (id == IDW'(NREQ - 1)) ? '0 : id + 1'b1;
    end
  end

endmodule

// File: rtl/mbus_ctl.sv
// rtl/mbus_ctl.sv - MBUS master: arbitrates quadword reads, runs one MBUS cycle at a time
module mbus_ctl
  import kl10pv::*;
#(
  parameter int NREQ = 2,
  parameter int TIMEOUT = 64,
  localparam int IDW = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [NREQ-1:0]        rqValid,
  input  logic [NREQ-1:0][14:35] rqAdr,
  input  logic [NREQ-1:0][0:3]   rqMask,
  output logic [NREQ-1:0]        rqGrant,
  output logic                   rdValid,
  output logic [W36-1:0]         rdData,
  output logic [34:35]           rdWo,
  output logic [IDW-1:0]         rdId,
  output logic                   rdParErr,
  output logic                   rdDone,
  output logic                   nxmErr,
  output logic [14:35]           mbAdr,
  output logic [0:3]             mbRq,
  output logic                   mbAdrHold,
  output logic                   mbStartA,
  output logic                   mbStartB,
  input  logic                   mbAcknA,
  input  logic                   mbAcknB,
  input  logic                   mbValidA,
  input  logic                   mbValidB,
  input  logic [W36-1:0]         mbD,
  input  logic                   mbPar,
  output logic                   mbMemReset
);

  localparam int CW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {ST_IDLE, ST_START, ST_WAIT, ST_DATA} state_t;

  state_t         state, state_n;
  mbus_req_t      cur, cur_n;
  logic [IDW-1:0] cur_id, id_n;
  logic [0:3]     rem, rem_n;
  logic [CW-1:0]  cnt, cnt_n;
  logic           rd_valid_r, vld_n, rd_par_r, par_n, rd_done_r, done_n, nxm_r, nxm_n;
  logic [W36-1:0] rd_data_r, data_n;
  logic [1:0]     rd_wo_r, wo_n, k;

  logic [NREQ-1:0] arb_grant;
  logic [IDW-1:0]  arb_id;
  logic            arb_any, advance, take, act, ack_sel, vld_sel;
  mbus_phase_t     ph;

  mbus_rr_arb #(.NREQ(NREQ)) u_arb (
    .clk     (clk),
    .reset   (reset),
    .req     (rqValid),
    .advance (advance),
    .grant   (arb_grant),
    .id      (arb_id),
    .any     (arb_any)
  );

  assign ph      = mbus_phase_t'(cur.adr[33]);
  assign ack_sel = (ph == PH_B) ? mbAcknB : mbAcknA;
  assign vld_sel = (ph == PH_B) ? mbValidB : mbValidA;
  assign k       = first_set(rem);

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= ST_IDLE;
      cur        <= '0;
      cur_id     <= '0;
      rem        <= '0;
      cnt        <= '0;
      rd_valid_r <= 1'b0;
      rd_data_r  <= '0;
      rd_wo_r    <= '0;
      rd_par_r   <= 1'b0;
      rd_done_r  <= 1'b0;
      nxm_r      <= 1'b0;
    end else begin
      state      <= state_n;
      cur        <= cur_n;
      cur_id     <= id_n;
      rem        <= rem_n;
      cnt        <= cnt_n;
      rd_valid_r <= vld_n;
      rd_data_r  <= data_n;
      rd_wo_r    <= wo_n;
      rd_par_r   <= par_n;
      rd_done_r  <= done_n;
      nxm_r      <= nxm_n;
    end
  end

  always_comb begin
    state_n = state;
    cur_n   = cur;
    id_n    = cur_id;
    rem_n   = rem;
    cnt_n   = cnt;
    vld_n   = 1'b0;
    data_n  = rd_data_r;
    wo_n    = rd_wo_r;
    par_n   = 1'b0;
    done_n  = 1'b0;
    nxm_n   = 1'b0;
    advance = 1'b0;
    take    = 1'b0;
    case (state)
      ST_IDLE: begin
        if (arb_any) begin
          advance  = 1'b1;
          cur_n    = '{adr: rqAdr[arb_id], mask: rqMask[arb_id]};
          id_n     = arb_id;
          rem_n    = rqMask[arb_id];
          cnt_n    = '0;
          // An empty mask needs no memory cycle at all.
          if (rqMask[arb_id] == 4'b0000) done_n = 1'b1;
          else                           state_n = ST_START;
        end
      end
      ST_START: begin
        cnt_n = CW'(1);
        if (ack_sel) begin
          state_n = ST_DATA;
          take    = vld_sel;
        end else begin
          state_n = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (ack_sel) begin
          state_n = ST_DATA;
          take    = vld_sel;
        end else if (cnt == CW'(TIMEOUT - 1)) begin
          done_n  = 1'b1;
          nxm_n   = 1'b1;
          state_n = ST_IDLE;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      default: take = vld_sel;
    endcase
    if (take) begin
      vld_n    = 1'b1;
      data_n   = mbD;
      par_n    = (mbPar != ^mbD);
      wo_n     = cur.adr[34:35] + k;
      rem_n[k] = 1'b0;
      if (rem_n == 4'b0000) begin
        done_n  = 1'b1;
        state_n = ST_IDLE;
      end
    end
  end

  // Everything reads as idle while reset is held, whatever state the flops still hold.
  assign act        = ~reset;
  assign mbMemReset = reset;
  assign rqGrant    = (act && state == ST_IDLE) ? arb_grant : '0;
  assign mbAdrHold  = act && (state != ST_IDLE);
  assign mbAdr      = mbAdrHold ? cur.adr : '0;
  assign mbRq       = mbAdrHold ? cur.mask : '0;
  assign mbStartA   = act && (state == ST_START) && (ph == PH_A);
  assign mbStartB   = act && (state == ST_START) && (ph == PH_B);
  assign rdValid    = act & rd_valid_r;
  assign rdData     = act ? rd_data_r : '0;
  assign rdWo       = act ? rd_wo_r : '0;
  assign rdId       = act ? cur_id : '0;
  assign rdParErr   = act & rd_par_r;
  assign rdDone     = act & rd_done_r;
  assign nxmErr     = act & nxm_r;

endmodule

// File: tb/tb_mbus_ctl.sv
// tb/tb_mbus_ctl.sv - randomized bench for mbus_ctl with MB20 responder and scoreboard
module tb_mbus_ctl;

  localparam int NREQ = 2;
  localparam int TO   = 16;

  logic                   clk = 1'b0;
  logic                   reset;
  logic [NREQ-1:0]        rqValid;
  logic [NREQ-1:0][14:35] rqAdr;
  logic [NREQ-1:0][0:3]   rqMask;
  logic [NREQ-1:0]        rqGrant;
  logic                   rdValid, rdParErr, rdDone, nxmErr;
  logic [35:0]            rdData;
  logic [34:35]           rdWo;
  logic [0:0]             rdId;
  logic [14:35]           mbAdr;
  logic [0:3]             mbRq;
  logic                   mbAdrHold, mbStartA, mbStartB, mbMemReset;
  logic                   mbAcknA, mbAcknB, mbValidA, mbValidB, mbPar;
  logic [35:0]            mbD;

  mbus_ctl #(.NREQ(NREQ), .TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset), .rqValid(rqValid), .rqAdr(rqAdr), .rqMask(rqMask),
    .rqGrant(rqGrant), .rdValid(rdValid), .rdData(rdData), .rdWo(rdWo), .rdId(rdId),
    .rdParErr(rdParErr), .rdDone(rdDone), .nxmErr(nxmErr), .mbAdr(mbAdr), .mbRq(mbRq),
    .mbAdrHold(mbAdrHold), .mbStartA(mbStartA), .mbStartB(mbStartB),
    .mbAcknA(mbAcknA), .mbAcknB(mbAcknB), .mbValidA(mbValidA), .mbValidB(mbValidB),
    .mbD(mbD), .mbPar(mbPar), .mbMemReset(mbMemReset)
  );

  always #5 clk = ~clk;

  int n_chk = 0, n_pass = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) $display("FAIL %s: got %0h expected %0h at t=%0t", tag, got, exp, $time);
    else n_pass++;
  endtask

  // Shared knobs set by the stimulus and read by the responder/scoreboard.
  int   flip_word = 4;
  logic no_ack = 1'b0;

  // MB20-style memory: words equal their own address, ACKN after a random delay.
  initial begin : responder
    logic        rbusy, acked, m_ph, ack, vld, nz;
    logic [14:35] m_adr;
    logic [0:3]  m_rq;
    logic [1:0]  wo;
    logic [35:0] d;
    logic        p;
    int          ack_dly, rk, rwidx;
    rbusy = 1'b0; acked = 1'b0; m_ph = 1'b0; m_adr = '0; m_rq = '0;
    ack_dly = 0; rk = 0; rwidx = 0;
    {mbAcknA, mbAcknB, mbValidA, mbValidB, mbPar} = '0;
    mbD = '0;
    forever begin
      @(negedge clk);
      ack = 1'b0; vld = 1'b0; nz = 1'b0;
      d = {4'($urandom), 32'($urandom)};
      p = 1'($urandom);
      if (reset) begin
        rbusy = 1'b0;
      end else begin
        if (mbStartA || mbStartB) begin
          rbusy = 1'b1; m_adr = mbAdr; m_rq = mbRq; m_ph = mbStartB;
          ack_dly = $urandom_range(0, 3); acked = 1'b0; rk = 0; rwidx = 0;
        end
        nz = rbusy;
        if (rbusy) begin
          if (!acked && !no_ack) begin
            if (ack_dly == 0) begin ack = 1'b1; acked = 1'b1; end
            else ack_dly--;
          end
          if (acked && $urandom_range(0, 9) < 7) begin
            while (rk < 4 && !m_rq[rk]) rk++;
            wo = m_adr[34:35] + 2'(rk);
            d = {14'd0, m_adr[14:33], wo};
            p = (rwidx == flip_word) ? ~^d : ^d;
            vld = 1'b1;
            rk++; rwidx++;
            while (rk < 4 && !m_rq[rk]) rk++;
            if (rk >= 4) rbusy = 1'b0;
          end
        end
      end
      mbD = d; mbPar = p;
      if (m_ph) begin
        mbAcknB = ack; mbValidB = vld;
        mbAcknA = nz & 1'($urandom); mbValidA = nz & 1'($urandom);
      end else begin
        mbAcknA = ack; mbValidA = vld;
        mbAcknB = nz & 1'($urandom); mbValidB = nz & 1'($urandom);
      end
    end
  end

  typedef struct {
    logic [35:0] d;
    logic [1:0]  wo;
    logic        pe;
  } ent_t;

  ent_t        expq[$];
  int          gnt_cnt[NREQ];
  int          glog[$];
  int          done_cnt = 0, rd_cnt = 0, ptr = 0, cur_id = 0, start_cyc = 0;
  logic        busy_m = 1'b0, started = 1'b0;
  logic [14:35] cur_adr = '0;
  logic [0:3]  cur_mask = '0;

  initial foreach (gnt_cnt[i]) gnt_cnt[i] = 0;

  // Scoreboard: samples 3 time units after the negedge, well clear of posedge.
  initial begin : monitor
    ent_t e;
    int   ex, widx;
    logic [14:35] a;
    logic [0:3]   m;
    widx = 0;
    forever begin
      @(negedge clk); #3;
      if (reset) begin
        check("rst_memreset", mbMemReset, 1);
        check("rst_quiet", {rdValid, rdDone, nxmErr, mbAdrHold, mbStartA, mbStartB, rqGrant}, 0);
        expq.delete(); busy_m = 1'b0; started = 1'b0; ptr = 0;
      end else begin
        if (mbStartA || mbStartB) begin
          check("start_once", started, 0);
          check("start_needed", expq.size() != 0, 1);
          check("start_phase", {mbStartB, mbStartA}, cur_adr[33] ? 2 : 1);
          check("start_adr", {mbAdr, mbRq, mbAdrHold}, {cur_adr, cur_mask, 1'b1});
          started = 1'b1; start_cyc = cyc;
        end
        if (rdValid) begin
          rd_cnt++;
          if (expq.size() == 0) check("rd_spurious", 1, 0);
          else begin
            e = expq.pop_front();
            check("rd_data", rdData, e.d);
            check("rd_wo", rdWo, e.wo);
            check("rd_parerr", rdParErr, e.pe);
            check("rd_id", rdId, cur_id);
            check("rd_done_last", rdDone, expq.size() == 0);
          end
        end
        if (rdDone) begin
          check("done_busy", busy_m, 1);
          check("done_id", rdId, cur_id);
          check("done_memreset", mbMemReset, 0);
          if (!rdValid && expq.size() != 0) begin
            check("nxm", nxmErr, 1);
            check("nxm_latency", cyc - start_cyc, TO);
            expq.delete();
          end else begin
            check("nxm", nxmErr, 0);
          end
          busy_m = 1'b0; started = 1'b0; done_cnt++;
        end else if (nxmErr) begin
          check("nxm_without_done", 1, 0);
        end
        if (rqGrant != 0) begin
          check("grant_when_idle", busy_m, 0);
          ex = -1;
          for (int i = 0; i < NREQ; i++)
            if (ex < 0 && rqValid[(ptr + i) % NREQ]) ex = (ptr + i) % NREQ;
          check("grant", rqGrant, (ex < 0) ? 0 : (1 << ex));
          if (ex >= 0) begin
            ptr = (ex + 1) % NREQ;
            a = rqAdr[ex]; m = rqMask[ex];
            widx = 0;
            for (int kk = 0; kk < 4; kk++) begin
              if (m[kk]) begin
                e.wo = a[34:35] + 2'(kk);
                e.d  = {14'd0, a[14:33], e.wo};
                e.pe = (widx == flip_word);
                expq.push_back(e);
                widx++;
              end
            end
            cur_adr = a; cur_mask = m; cur_id = ex;
            busy_m = 1'b1; started = 1'b0;
            gnt_cnt[ex]++;
            glog.push_back(ex);
          end
        end
      end
    end
  end

  task automatic step();
    @(negedge clk); #1;
  endtask

  task automatic do_req(input int r, input logic [14:35] a, input logic [0:3] m);
    int g0, d0, t;
    g0 = gnt_cnt[r]; d0 = done_cnt; t = 0;
    rqAdr[r] = a; rqMask[r] = m; rqValid[r] = 1'b1;
    while (gnt_cnt[r] == g0 && t < 200) begin step(); t++; end
    rqValid[r] = 1'b0;
    check("grant_wait", gnt_cnt[r] != g0, 1);
    t = 0;
    while (done_cnt == d0 && t < 200) begin step(); t++; end
    check("done_wait", done_cnt != d0, 1);
  endtask

  task automatic wait_idle();
    int t;
    t = 0;
    while (busy_m && t < 200) begin step(); t++; end
    check("idle_wait", busy_m, 0);
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin : stim
    int g, t, r0;
    reset = 1'b1; rqValid = 2'b01; rqAdr = '0; rqMask = '0;
    repeat (3) step();
    rqValid = '0;
    step();
    reset = 1'b0;
    step();

    do_req(0, 22'o1000, 4'b1111);
    do_req(0, 22'o1003, 4'b1010);
    do_req(1, 22'o1004, 4'b1111);
    do_req(1, 22'o7777, 4'b0000);

    rqAdr[0] = 22'o2000; rqMask[0] = 4'b1111;
    rqAdr[1] = 22'o3005; rqMask[1] = 4'b0110;
    g = glog.size(); t = 0;
    rqValid = 2'b11;
    while (glog.size() < g + 6 && t < 500) begin step(); t++; end
    rqValid = '0;
    check("arb_grants", glog.size() >= g + 6, 1);
    for (int i = g + 1; i < glog.size(); i++) check("arb_alternate", glog[i] != glog[i-1], 1);
    wait_idle();

    no_ack = 1'b1;
    do_req(0, 22'o4000, 4'b1100);
    no_ack = 1'b0;
    do_req(1, 22'o4010, 4'b0011);

    for (int i = 0; i < 30; i++) begin
      flip_word = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 3) : 4;
      do_req($urandom_range(0, 1), 22'($urandom), 4'($urandom));
    end

    flip_word = 1;
    r0 = rd_cnt; t = 0;
    rqAdr[0] = 22'o5000; rqMask[0] = 4'b1111; rqValid[0] = 1'b1;
    while (rd_cnt < r0 + 2 && t < 200) begin
      step(); t++;
      if (busy_m) rqValid[0] = 1'b0;
    end
    rqValid[0] = 1'b0;
    check("par_words_seen", rd_cnt >= r0 + 2, 1);
    reset = 1'b1;
    repeat (2) step();
    reset = 1'b0;
    flip_word = 4;
    r0 = rd_cnt; g = done_cnt;
    repeat (20) step();
    check("post_reset_no_rd", rd_cnt - r0, 0);
    check("post_reset_no_done", done_cnt - g, 0);

    g = glog.size(); t = 0;
    rqAdr[0] = 22'o6000; rqMask[0] = 4'b1001;
    rqAdr[1] = 22'o6004; rqMask[1] = 4'b1111;
    rqValid = 2'b11;
    while (glog.size() == g && t < 200) begin step(); t++; end
    rqValid = '0;
    check("rr_after_reset", (glog.size() > g) ? glog[g] : -1, 0);
    wait_idle();

    repeat (5) step();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/mbus_ctl.md
Name: mbus_ctl

Overview:
MBUS master controller on the MBOX side of the KL10 model.
- Arbitrates quadword read requests from NREQ requesters (cache refill, channels, diagnostics) round-robin.
- Drives ADR/RQ/START onto MBUS to an MB20-style memory, collects the ACKN/VALID word stream and returns words with parity status.
- One MBUS cycle is outstanding at a time.

Parameters:
NREQ, 2, number of requesters (1..4)
TIMEOUT, 64, clk cycles allowed from START to first ACKN before a no-response error

Ports:
clk  in  1  MBUS clock; controller samples on posedge
reset  in  1  synchronous, active-high
rqValid  in  NREQ  requester i has a pending read
rqAdr  in  NREQ x [14:35]  word address per requester
rqMask  in  NREQ x [0:3]  words wanted; bit k = word (adr[34:35]+k) mod 4
rqGrant  out  NREQ  one-hot; 1-cycle pulse when requester's request is accepted
rdValid  out  1  returned word valid
rdData  out  W36  returned word
rdWo  out  [34:35]  word offset of rdData within quadword
rdId  out  [$clog2(NREQ)]  owning requester
rdParErr  out  1  parity mismatch on this word
rdDone  out  1  pulse: last word of cycle delivered, or error termination
nxmErr  out  1  pulse with rdDone on ACKN timeout
mbAdr  out  [14:35]  MBUS address
mbRq  out  [0:3]  MBUS request mask
mbAdrHold  out  1  MBUS address hold
mbStartA  out  1  START phase A
mbStartB  out  1  START phase B
mbAcknA / mbAcknB  in  1  acknowledge per phase
mbValidA / mbValidB  in  1  data valid per phase
mbD  in  W36  MBUS read data
mbPar  in  1  MBUS data parity
mbMemReset  out  1  memory reset

Behaviour:
- Reset (synchronous): state IDLE; all outputs 0 except mbMemReset=1 while reset high; round-robin pointer = 0; timeout counter cleared. Reset mid-cycle abandons the cycle without rdDone.
- Phase select: phase = mbAdr[33] (0 -> A, 1 -> B), fixed for the cycle.
- States:
  - IDLE: if any rqValid, pick the first set bit at or after rrPtr (wrapping); latch adr/mask/id; pulse rqGrant; rrPtr <= id+1 mod NREQ; go START. A requester with rqMask==0 is granted and immediately completes (rdDone, no MBUS activity).
  - START: mbAdr/mbRq driven, mbAdrHold=1; assert the phase START for exactly 1 cycle; go WAIT.
  - WAIT: hold mbAdr/mbRq/mbAdrHold. Count cycles; ACKN on the selected phase -> go DATA, processing that cycle's word as below. Counter reaching TIMEOUT -> rdDone=1, nxmErr=1, go IDLE.
  - DATA: each cycle with the selected phase's VALID high delivers the next remaining word.
    - rdValid=1 one cycle later (registered), rdData=mbD.
    - rdWo = (adr[34:35] + k) mod 4, where k = the next set mask bit, walked left to right.
    - rdParErr = (mbPar != ^mbD).
    - Cycles with VALID low are gaps and are skipped.
  - Completion: after popcount(mask) words, rdDone is asserted with the last rdValid; go IDLE. The next grant may occur in the same cycle as rdDone.
- Signals on the non-selected phase are ignored. ACKN arriving in the START cycle counts as WAIT's ACKN.
- rqValid dropping after grant has no effect on the cycle.
- Word offset arithmetic is 2-bit with wrap: start 3, mask 1111 -> 3,0,1,2.

Decomposition:
- Shared package (kl10pv): W36, an MBUS phase enum {PH_A, PH_B}, and a request struct {adr[14:35], mask[0:3]}.
- One sub-module, mbus_rr_arb: NREQ round-robin arbiter (req, advance -> grant one-hot, id). The FSM and datapath stay in mbus_ctl.

Test Plan:
- Single read, rqAdr[0]=0o1000, mask 1111, memory words = address: mbStartA for 1 cycle; 4 rdValid with rdWo 0,1,2,3, data 0o1000..0o1003; rdDone on the 4th; rdParErr=0.
- Wrap and partial mask, adr=0o1003 (adr[33]=0 -> phase A), mask 1010: 2 words with rdWo 3 and 1; rdDone after the 2nd.
- Phase B, adr=0o1004 (adr[33]=1): only mbStartB pulses; VALID injected on phase A is ignored; data comes from phase B.
- Arbitration, both requesters continuously valid: grants alternate 0,1,0,1; rdId matches each grant; no overlap between cycles.
- Timeout, memory never ACKNs: rdDone and nxmErr pulse exactly TIMEOUT cycles after START; the next request is then granted.
- Parity flip on word 2 plus reset mid-DATA: rdParErr=1 only on that word; reset asserted during the 3rd word returns to IDLE with no further rdValid or rdDone, and mbMemReset=1.
